sc_robert_ctrl: RTL and testbench
=================================

SC_ROBERT_CTRL -- requirements
Module: sc_robert_ctrl

Interface
REQ-001 SHALL have parameter LEN_LOG2, default 8, log2 of the stochastic stream length LEN.
REQ-002 SHALL have parameter DP_LAT, default 2, the cycle latency from stream bits to dp_out.
REQ-003 SHALL have parameter SEED_P, default 8'h01, the reload value of the pixel LFSR.
REQ-004 SHALL have parameter SEED_S, default 8'hA5, the reload value of the select LFSR.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  pixel window offered.
REQ-008 in_ready  out  1  window accepted when high together with in_valid.
REQ-009 px00, px01, px10, px11  in  8 each  unsigned pixel values of the 2x2 window.
REQ-010 r00, r01, r10, r11  out  1 each  stochastic stream bits to the datapath.
REQ-011 sel  out  1  select stream bit to the datapath, probability 0.5.
REQ-012 dp_clr  out  1  synchronous clear pulse for datapath state (abs units).
REQ-013 dp_out  in  1  datapath output stream bit.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  result consumed when high together with out_valid.
REQ-016 out_count  out  LEN_LOG2+1  number of ones captured from dp_out.

Function
REQ-017 SHALL implement an FSM with the states IDLE, CLR, BUSY and DONE.
REQ-018 IDLE: in_ready=1; on in_valid&in_ready, latch px00..px11 and go to CLR.
REQ-019 CLR: exactly one cycle; dp_clr=1; both LFSRs loaded with their seeds; ones counter and cycle counter zeroed; go to BUSY.
REQ-020 BUSY: lasts LEN+DP_LAT cycles, counted by cyc from 0 to LEN+DP_LAT-1; both LFSRs advance every cycle; go to DONE after the last cycle.
REQ-021 Pixel LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, never zero.
REQ-022 Select LFSR: 8-bit with the same polynomial, independent seed.
REQ-023 sel SHALL equal the select LFSR MSB.
REQ-024 In BUSY, rXY = (pxXY > pixel LFSR value), registered; all four streams share the pixel LFSR.
REQ-025 Outside BUSY, r00..r11 and sel SHALL be 0.
REQ-026 In BUSY, while cyc >= DP_LAT, the block SHALL add dp_out to the ones counter; exactly LEN bits are captured.
REQ-027 out_count range is 0..LEN, with no saturation needed.
REQ-028 DONE: out_valid=1 and out_count stable until out_ready; on out_ready, go to IDLE; in_ready=0.
REQ-029 in_ready SHALL be 0 in CLR, BUSY and DONE; no new window is accepted until the result is consumed.
REQ-030 Latency: handshake at cycle T -> CLR at T+1 -> BUSY T+2..T+1+LEN+DP_LAT -> out_valid from T+2+LEN+DP_LAT (T+260 at defaults).
REQ-031 Input pixel changes after acceptance SHALL have no effect on the current run.
REQ-032 out_valid and out_ready high in the same cycle as in_valid: the result is consumed, and the new window is accepted only in the next IDLE cycle.

Reset
REQ-033 Reset asserted SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, out_count=0, r*/sel=0, dp_clr=0, counters=0, LFSRs=seeds.
REQ-034 Reset asserted mid-BUSY or in DONE SHALL abort the run; the pending result is discarded.
REQ-035 After deassertion, operation SHALL resume from IDLE on the next rising edge.

Structure
REQ-036 The shared package SHALL hold the FSM state enum, the LFSR polynomial tap constant, and the default seeds.
REQ-037 LFSR SHALL be a sub-module sc_lfsr8 (seed load, enable, 8-bit state), instantiated twice.
REQ-038 The datapath SHALL be instantiated outside the block and wired via r*/sel/dp_out/dp_clr.

Verification
REQ-039 Stub dp_out=1, any window -> out_count=256, out_valid at T+260.
REQ-040 Stub dp_out=0 -> out_count=0; px all 8'h00 -> r* never 1 in BUSY.
REQ-041 px00=8'hFF -> r00=0 only in BUSY cycles where the pixel LFSR equals 8'hFF; sel ones count within 128±16 over a run.
REQ-042 out_ready held low 50 cycles after out_valid -> out_valid and out_count held, in_ready=0, second in_valid ignored until consumed.
REQ-043 Reset asserted at cyc=100 of BUSY -> next cycle state IDLE, out_valid=0; a fresh run gives a result identical to an undisturbed run.
REQ-044 Full datapath, px00=px11=px10=px01=8'h80 -> out_count within expected model value ±8, matched against a cycle-accurate reference model.

Source files
------------

// File: rtl/sc_robert_ctrl_pkg.sv
// Shared types and constants for the stochastic Roberts-cross controller.
// Holds the FSM states, the LFSR tap mask, the default seeds and the pixel-window layout.
package sc_robert_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    // x^8+x^6+x^5+x^4+1 : taps at state bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] SEED_P_DEF = 8'h01;
    localparam logic [7:0] SEED_S_DEF = 8'hA5;

    typedef struct packed {
        logic [7:0] p00;
        logic [7:0] p01;
        logic [7:0] p10;
        logic [7:0] p11;
    } px_win_t;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_robert_ctrl_if.sv
// Bundle of the window/result handshakes and the datapath stream wires.
// slave = controller side, master = environment (source, sink and external datapath).
interface sc_robert_ctrl_if #(
    parameter int LEN_LOG2 = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        px00;
    logic [7:0]        px01;
    logic [7:0]        px10;
    logic [7:0]        px11;
    logic              r00;
    logic              r01;
    logic              r10;
    logic              r11;
    logic              sel;
    logic              dp_clr;
    logic              dp_out;
    logic              out_valid;
    logic              out_ready;
    logic [LEN_LOG2:0] out_count;

    modport slave (
        input  in_valid, px00, px01, px10, px11, dp_out, out_ready,
        output in_ready, r00, r01, r10, r11, sel, dp_clr, out_valid, out_count
    );

    modport master (
        output in_valid, px00, px01, px10, px11, dp_out, out_ready,
        input  in_ready, r00, r01, r10, r11, sel, dp_clr, out_valid, out_count
    );
endinterface

// File: rtl/sc_lfsr8.sv
// 8-bit Fibonacci LFSR with seed load and advance enable; reset and load both give SEED.
// o_next is the value the register takes at the coming edge, so consumers can register in step.
module sc_lfsr8
    import sc_robert_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = SEED_P_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_en,
    output logic [7:0] o_next
);
    logic [7:0] r_state;

    always_comb begin
        o_next = r_state;
        if (i_load) begin
            o_next = SEED;
        end else if (i_en) begin
            o_next = lfsr8_step(r_state);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEED;
        end else begin
            r_state <= o_next;
        end
    end

endmodule

// File: rtl/sc_robert_ctrl.sv
// Controller for a stochastic Roberts-cross pixel: drives LEN stream bits, counts LEN datapath ones.
// Window handshake -> result after LEN+DP_LAT+2 cycles; result held until out_ready, no new window meanwhile.
module sc_robert_ctrl
    import sc_robert_ctrl_pkg::*;
#(
    parameter int         LEN_LOG2 = 8,
    parameter int         DP_LAT   = 2,
    parameter logic [7:0] SEED_P   = SEED_P_DEF,
    parameter logic [7:0] SEED_S   = SEED_S_DEF
) (
    input  logic          clk,
    input  logic          reset,
    sc_robert_ctrl_if.slave bus
);
    localparam int LEN   = 1 << LEN_LOG2;
    localparam int CYC_W = $clog2(LEN + DP_LAT + 1);
    localparam int CNT_W = LEN_LOG2 + 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(LEN + DP_LAT - 1);
    localparam logic [CYC_W-1:0] CYC_CAP  = CYC_W'(DP_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    px_win_t           r_px;
    logic [CYC_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_r00;
    logic              r_r01;
    logic              r_r10;
    logic              r_r11;
    logic              r_sel;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_dp_clr;
    logic              w_lfsr_load;
    logic              w_lfsr_en;
    logic              w_last;
    logic              w_next_busy;
    logic [7:0]        w_p_nxt;
    logic [7:0]        w_s_nxt;

    assign w_last      = (r_cyc == CYC_LAST);
    assign w_next_busy = (w_state_nxt == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_dp_clr    = 1'b0;
        w_lfsr_load = 1'b0;
        w_lfsr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = CLR;
                end
            end
            CLR: begin
                w_dp_clr    = 1'b1;
                w_lfsr_load = 1'b1;
                w_state_nxt = BUSY;
            end
            BUSY: begin
                w_lfsr_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    sc_lfsr8 #(
        .SEED (SEED_P)
    ) u_lfsr_px (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_lfsr_load),
        .i_en   (w_lfsr_en),
        .o_next (w_p_nxt)
    );

    sc_lfsr8 #(
        .SEED (SEED_S)
    ) u_lfsr_sel (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_lfsr_load),
        .i_en   (w_lfsr_en),
        .o_next (w_s_nxt)
    );

    // The window is captured once; later pixel changes cannot reach the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_px <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_px <= '{p00: bus.px00, p01: bus.px01, p10: bus.px10, p11: bus.px11};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                CLR: begin
                    r_cyc <= '0;
                    r_cnt <= '0;
                end
                BUSY: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (r_cyc >= CYC_CAP) begin
                        r_cnt <= r_cnt + CNT_W'(bus.dp_out);
                    end
                end
                default: begin
                    r_cyc <= r_cyc;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Compared against the LFSR's next value so each BUSY cycle shows the bit of the LFSR value it holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_r00 <= 1'b0;
            r_r01 <= 1'b0;
            r_r10 <= 1'b0;
            r_r11 <= 1'b0;
            r_sel <= 1'b0;
        end else begin
            r_r00 <= w_next_busy & (r_px.p00 > w_p_nxt);
            r_r01 <= w_next_busy & (r_px.p01 > w_p_nxt);
            r_r10 <= w_next_busy & (r_px.p10 > w_p_nxt);
            r_r11 <= w_next_busy & (r_px.p11 > w_p_nxt);
            r_sel <= w_next_busy & w_s_nxt[7];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.dp_clr    = w_dp_clr;
    assign bus.out_count = r_cnt;
    assign bus.r00       = r_r00;
    assign bus.r01       = r_r01;
    assign bus.r10       = r_r10;
    assign bus.r11       = r_r11;
    assign bus.sel       = r_sel;

endmodule

// File: tb/tb_sc_robert_ctrl.sv
// Directed bench for sc_robert_ctrl with stub and two-stage XOR/mux datapath on dp_out.
// Stream bits and datapath results are predicted by an independent LFSR model.
module tb_sc_robert_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   dp_mode = 0;

    always #5 clk = ~clk;

    sc_robert_ctrl_if #(.LEN_LOG2(8)) bus();

    sc_robert_ctrl #(
        .LEN_LOG2 (8),
        .DP_LAT   (2),
        .SEED_P   (8'h01),
        .SEED_S   (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Two-stage datapath: |a-b| via XOR of correlated streams, then sel mux.
    logic st1_a = 1'b0, st1_b = 1'b0, st1_s = 1'b0, st2 = 1'b0;
    always_ff @(posedge clk) begin
        if (bus.dp_clr) begin
            st1_a <= 1'b0;
            st1_b <= 1'b0;
            st1_s <= 1'b0;
            st2   <= 1'b0;
        end else begin
            st1_a <= bus.r00 ^ bus.r11;
            st1_b <= bus.r01 ^ bus.r10;
            st1_s <= bus.sel;
            st2   <= st1_s ? st1_a : st1_b;
        end
    end

    assign bus.dp_out = (dp_mode == 0) ? 1'b0 : (dp_mode == 1) ? 1'b1 : st2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int model_count(input logic [7:0] a00, a01, a10, a11);
        logic [7:0] s;
        logic [7:0] t;
        logic       a;
        logic       b;
        int         c;
        s = 8'h01;
        t = 8'hA5;
        c = 0;
        for (int k = 0; k < 256; k++) begin
            a = (a00 > s) ^ (a11 > s);
            b = (a01 > s) ^ (a10 > s);
            c += int'(t[7] ? a : b);
            s = mstep(s);
            t = mstep(t);
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic run_window(input logic [7:0] a00, a01, a10, a11,
                              output int lat, output int mis, output int sel_ones);
        logic [7:0] s;
        logic [7:0] t;
        bus.in_valid = 1'b1;
        bus.px00 = a00; bus.px01 = a01; bus.px10 = a10; bus.px11 = a11;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.px00 = ~a00; bus.px01 = ~a01; bus.px10 = ~a10; bus.px11 = ~a11;
        s = 8'h01;
        t = 8'hA5;
        lat = -1;
        mis = 0;
        sel_ones = 0;
        for (int n = 1; n <= 400; n++) begin
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.in_ready !== 1'b0) mis++;
            if (bus.dp_clr !== (n == 1)) mis++;
            if (n >= 2 && n <= 259) begin
                if (bus.r00 !== (a00 > s)) mis++;
                if (bus.r01 !== (a01 > s)) mis++;
                if (bus.r10 !== (a10 > s)) mis++;
                if (bus.r11 !== (a11 > s)) mis++;
                if (bus.sel !== t[7]) mis++;
                if (n <= 257) sel_ones += int'(bus.sel);
                s = mstep(s);
                t = mstep(t);
            end else if ({bus.r00, bus.r01, bus.r10, bus.r11, bus.sel} !== 5'b0) begin
                mis++;
            end
            @(negedge clk);
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    int lat, mis, sel_ones, exp_c, exp_d, hold_err;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.px00 = 8'h00; bus.px01 = 8'h00; bus.px10 = 8'h00; bus.px11 = 8'h00;
        rst_n = 1'b0;
        exp_c = model_count(8'hFF, 8'h80, 8'h20, 8'h40);
        exp_d = model_count(8'h80, 8'h80, 8'h80, 8'h80);

        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_count", 32'(bus.out_count), 0);
        chk("rst_streams", 32'({bus.r00, bus.r01, bus.r10, bus.r11, bus.sel}), 0);
        chk("rst_dp_clr", 32'(bus.dp_clr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // dp_out stuck at 1: every captured bit counts
        dp_mode = 1;
        run_window(8'h12, 8'h34, 8'h56, 8'h78, lat, mis, sel_ones);
        chk("A_latency", 32'(lat), 260);
        chk("A_streams", 32'(mis), 0);
        chk("A_out_count", 32'(bus.out_count), 256);
        chk("A_sel_range", 32'((sel_ones >= 112 && sel_ones <= 144) ? 1 : 0), 1);
        consume();
        chk("A_consumed_valid", 32'(bus.out_valid), 0);
        chk("A_consumed_ready", 32'(bus.in_ready), 1);

        // dp_out stuck at 0, all-zero window
        dp_mode = 0;
        run_window(8'h00, 8'h00, 8'h00, 8'h00, lat, mis, sel_ones);
        chk("B_latency", 32'(lat), 260);
        chk("B_streams", 32'(mis), 0);
        chk("B_out_count", 32'(bus.out_count), 0);
        consume();

        // full datapath, px00=FF, then a 50-cycle stall with a pending window
        dp_mode = 2;
        run_window(8'hFF, 8'h80, 8'h20, 8'h40, lat, mis, sel_ones);
        chk("C_latency", 32'(lat), 260);
        chk("C_streams", 32'(mis), 0);
        chk("C_out_count", 32'(bus.out_count), 32'(exp_c));
        bus.in_valid = 1'b1;
        bus.px00 = 8'h80; bus.px01 = 8'h80; bus.px10 = 8'h80; bus.px11 = 8'h80;
        hold_err = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid !== 1'b1) hold_err++;
            if (bus.in_ready !== 1'b0) hold_err++;
            if (32'(bus.out_count) !== 32'(exp_c)) hold_err++;
            @(negedge clk);
        end
        chk("C_hold", 32'(hold_err), 0);
        consume();
        chk("C_same_cycle_valid", 32'(bus.out_valid), 0);
        chk("C_same_cycle_ready", 32'(bus.in_ready), 1);

        run_window(8'h80, 8'h80, 8'h80, 8'h80, lat, mis, sel_ones);
        chk("D_latency", 32'(lat), 260);
        chk("D_streams", 32'(mis), 0);
        chk("D_out_count", 32'(bus.out_count), 32'(exp_d));
        consume();

        // abort at cyc=100 of BUSY, then rerun the same window
        bus.in_valid = 1'b1;
        bus.px00 = 8'hFF; bus.px01 = 8'h80; bus.px10 = 8'h20; bus.px11 = 8'h40;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (101) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("E_abort_in_ready", 32'(bus.in_ready), 1);
        chk("E_abort_out_valid", 32'(bus.out_valid), 0);
        chk("E_abort_out_count", 32'(bus.out_count), 0);
        chk("E_abort_streams", 32'({bus.r00, bus.r01, bus.r10, bus.r11, bus.sel, bus.dp_clr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_window(8'hFF, 8'h80, 8'h20, 8'h40, lat, mis, sel_ones);
        chk("E_latency", 32'(lat), 260);
        chk("E_streams", 32'(mis), 0);
        chk("E_out_count", 32'(bus.out_count), 32'(exp_c));
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
